// File: rtl/cpu_trace_buffer.sv
// Execution-trace capture unit: snapshots pc and registers on a programmable
// condition into a show-ahead FIFO that a host drains over valid/ready.
module cpu_trace_buffer #(
    parameter int unsigned DATA_W = 19,
    parameter int unsigned PC_W   = 10,
    parameter int unsigned NREG   = 3,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TS_W   = 16
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [1:0]                               mode,
    input  logic [PC_W-1:0]                          trig_pc,
    input  logic                                     clear,
    input  logic [PC_W-1:0]                          pc_in,
    input  logic [NREG*DATA_W-1:0]                   regs_in,
    output logic                                     rd_valid,
    input  logic                                     rd_ready,
    output logic [TS_W+PC_W+NREG+NREG*DATA_W-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]                   count,
    output logic                                     overflow,
    output logic [7:0]                               drop_cnt,
    output logic                                     armed
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned REGS_W  = NREG * DATA_W;
    localparam int unsigned ENTRY_W = TS_W + PC_W + NREG + REGS_W;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_CHANGE = 2'b01,
        MODE_ALL    = 2'b10,
        MODE_TRIG   = 2'b11
    } mode_e;

    logic [TS_W-1:0]    ts;
    logic [REGS_W-1:0]  snap;
    logic               snap_valid;
    logic [NREG-1:0]    mask;
    logic               trig_hit;
    logic               capture;
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               drop;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] mem [DEPTH];

    // Per-register change detection; everything counts as changed until a snapshot exists
    always_comb begin
        mask = '0;
        for (int i = 0; i < NREG; i++) begin
            mask[i] = !snap_valid || (regs_in[i*DATA_W +: DATA_W] != snap[i*DATA_W +: DATA_W]);
        end
    end

    // Arming is effective on the same clock the trigger address is seen
    assign trig_hit = (mode_e'(mode) == MODE_TRIG) && (armed || (pc_in == trig_pc));

    // Capture condition selected by mode
    always_comb begin
        capture = 1'b0;
        case (mode_e'(mode))
            MODE_OFF:    capture = 1'b0;
            MODE_CHANGE: capture = |mask;
            MODE_ALL:    capture = 1'b1;
            MODE_TRIG:   capture = trig_hit && (|mask);
            default:     capture = 1'b0;
        endcase
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop   = !clear && !empty && rd_ready;
    assign push  = !clear && capture && (!full || pop);
    assign drop  = !clear && capture && full && !pop;
    assign entry = {ts, pc_in, mask, regs_in};

    assign rd_valid = !empty;
    assign rd_data  = rd_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;
    assign count    = wr_ptr - rd_ptr;

    // Free-running timestamp, untouched by mode and clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts <= '0;
        else        ts <= ts + TS_W'(1);
    end

    // Last-seen register values for change detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap       <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap       <= regs_in;
            snap_valid <= !clear;
        end
    end

    // Trigger latch, only held while in triggered mode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) armed <= 1'b0;
        else        armed <= trig_hit && !clear;
    end

    // FIFO pointers with an extra wrap bit for full/empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= entry;
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: directed table, hand sequences and a random run
// checked against a queue-based reference model.
module tb_cpu_trace_buffer;

    localparam int unsigned DATA_W  = 19;
    localparam int unsigned PC_W    = 10;
    localparam int unsigned NREG    = 3;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TS_W    = 16;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned REGS_W  = NREG * DATA_W;
    localparam int unsigned ENTRY_W = TS_W + PC_W + NREG + REGS_W;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          mode;
    logic [PC_W-1:0]     trig_pc;
    logic                clear;
    logic [PC_W-1:0]     pc_in;
    logic [REGS_W-1:0]   regs_in;
    logic                rd_valid;
    logic                rd_ready;
    logic [ENTRY_W-1:0]  rd_data;
    logic [CNT_W-1:0]    count;
    logic                overflow;
    logic [7:0]          drop_cnt;
    logic                armed;

    cpu_trace_buffer #(
        .DATA_W(DATA_W), .PC_W(PC_W), .NREG(NREG), .DEPTH(DEPTH), .TS_W(TS_W)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .trig_pc(trig_pc), .clear(clear),
        .pc_in(pc_in), .regs_in(regs_in), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
        .armed(armed)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [ENTRY_W-1:0] mq[$];
    int unsigned        m_ts;
    logic [DATA_W-1:0]  m_snap [NREG];
    bit                 m_snap_valid;
    bit                 m_armed;
    bit                 m_ovf;
    int                 m_drop;

    function automatic void model_reset();
        mq.delete();
        m_ts = 0;
        m_snap_valid = 1'b0;
        m_armed = 1'b0;
        m_ovf = 1'b0;
        m_drop = 0;
        for (int i = 0; i < NREG; i++) m_snap[i] = '0;
    endfunction

    // One clock of trace behaviour from the current inputs
    function automatic void model_clock();
        logic [NREG-1:0] msk;
        bit hit;
        bit cap;
        msk = '0;
        hit = 1'b0;
        cap = 1'b0;
        if (clear) begin
            mq.delete();
            m_ovf = 1'b0;
            m_drop = 0;
            m_armed = 1'b0;
            m_snap_valid = 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++)
                msk[i] = !m_snap_valid || (regs_in[i*DATA_W +: DATA_W] != m_snap[i]);
            hit = (mode == 2'b11) && (m_armed || (pc_in == trig_pc));
            case (mode)
                2'b00:   cap = 1'b0;
                2'b01:   cap = (msk != 0);
                2'b10:   cap = 1'b1;
                default: cap = hit && (msk != 0);
            endcase
            if (rd_ready && mq.size() > 0) void'(mq.pop_front());
            if (cap) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back({TS_W'(m_ts), pc_in, msk, regs_in});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            m_armed = hit;
            m_snap_valid = 1'b1;
        end
        for (int i = 0; i < NREG; i++) m_snap[i] = regs_in[i*DATA_W +: DATA_W];
        m_ts = (m_ts + 1) % (1 << TS_W);
    endfunction

    task automatic check_model();
        logic [ENTRY_W-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk("model_valid", 128'(rd_valid), 128'(mq.size() > 0));
        chk("model_count", 128'(count), 128'(mq.size()));
        chk("model_data", 128'(rd_data), 128'(head));
        chk("model_overflow", 128'(overflow), 128'(m_ovf));
        chk("model_drop_cnt", 128'(drop_cnt), 128'(m_drop));
        chk("model_armed", 128'(armed), 128'(m_armed));
    endtask

    // Advance one clock with inputs held, then compare against the model
    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Async reset: outputs must drop before any clock edge
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_valid", 128'(rd_valid), 128'(0));
        chk("rst_data", 128'(rd_data), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
        chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
        chk("rst_armed", 128'(armed), 128'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #4;
        reset = 1'b1;
    endtask

    function automatic logic [REGS_W-1:0] pack_regs(input int a, input int b, input int c);
        return {DATA_W'(c), DATA_W'(b), DATA_W'(a)};
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]        mode;
        logic [PC_W-1:0]   pc;
        int                r0, r1, r2;
        logic              rdy;
        logic              ev;
        int                ec;
        int                ets;
        logic [PC_W-1:0]   epc;
        logic [NREG-1:0]   emask;
        int                e0, e1, e2;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ENTRY_W-1:0] exp_entry;
        logic [TS_W-1:0]    prev_ts;
        int                 rdy_pct;

        tbl[0] = '{2'b01, 10'd0, 5, 6, 7, 1'b0, 1'b1, 1, 0, 10'd0, 3'b111, 5, 6, 7};
        tbl[1] = '{2'b01, 10'd1, 5, 6, 7, 1'b0, 1'b1, 1, 0, 10'd0, 3'b111, 5, 6, 7};
        tbl[2] = '{2'b01, 10'd2, 5, 6, 7, 1'b0, 1'b1, 1, 0, 10'd0, 3'b111, 5, 6, 7};
        tbl[3] = '{2'b01, 10'd4, 5, 9, 7, 1'b0, 1'b1, 2, 0, 10'd0, 3'b111, 5, 6, 7};
        tbl[4] = '{2'b01, 10'd5, 5, 9, 7, 1'b1, 1'b1, 1, 3, 10'd4, 3'b010, 5, 9, 7};
        tbl[5] = '{2'b01, 10'd6, 5, 9, 7, 1'b1, 1'b0, 0, 0, 10'd0, 3'b000, 0, 0, 0};

        reset = 1'b1;
        mode = 2'b01;
        trig_pc = '0;
        clear = 1'b0;
        pc_in = '0;
        regs_in = pack_regs(5, 6, 7);
        rd_ready = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Reset-first entry and single-register change
        for (int i = 0; i < 6; i++) begin
            mode = tbl[i].mode;
            pc_in = tbl[i].pc;
            regs_in = pack_regs(tbl[i].r0, tbl[i].r1, tbl[i].r2);
            rd_ready = tbl[i].rdy;
            step();
            exp_entry = tbl[i].ev ? {TS_W'(tbl[i].ets), tbl[i].epc, tbl[i].emask,
                                     pack_regs(tbl[i].e0, tbl[i].e1, tbl[i].e2)} : '0;
            chk($sformatf("tbl%0d_valid", i), 128'(rd_valid), 128'(tbl[i].ev));
            chk($sformatf("tbl%0d_count", i), 128'(count), 128'(tbl[i].ec));
            chk($sformatf("tbl%0d_data", i), 128'(rd_data), 128'(exp_entry));
        end

        // Overflow from a fresh reset, then drain
        rd_ready = 1'b0;
        mode = 2'b10;
        do_reset();
        repeat (20) step();
        chk("ovf_count", 128'(count), 128'(16));
        chk("ovf_flag", 128'(overflow), 128'(1));
        chk("ovf_drop_cnt", 128'(drop_cnt), 128'(4));
        mode = 2'b00;
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_ts%0d", i), 128'(rd_data[ENTRY_W-1 -: TS_W]), 128'(i));
            step();
        end
        chk("drain_empty", 128'(rd_valid), 128'(0));

        // Clear with entries queued and overflow sticky
        mode = 2'b10;
        rd_ready = 1'b0;
        repeat (5) step();
        chk("preclr_count", 128'(count), 128'(5));
        chk("preclr_overflow", 128'(overflow), 128'(1));
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_count", 128'(count), 128'(0));
        chk("clr_overflow", 128'(overflow), 128'(0));
        chk("clr_drop_cnt", 128'(drop_cnt), 128'(0));
        mode = 2'b01;
        step();
        chk("clr_next_mask", 128'(rd_data[REGS_W +: NREG]), 128'(3'b111));

        // Push and pop together at full
        mode = 2'b10;
        repeat (15) step();
        chk("full_count", 128'(count), 128'(16));
        rd_ready = 1'b1;
        prev_ts = rd_data[ENTRY_W-1 -: TS_W];
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pp_count", 128'(count), 128'(16));
            chk("pp_drop_cnt", 128'(drop_cnt), 128'(0));
            chk("pp_ts_step", 128'(rd_data[ENTRY_W-1 -: TS_W]), 128'(TS_W'(prev_ts + TS_W'(1))));
            prev_ts = rd_data[ENTRY_W-1 -: TS_W];
        end

        // Triggered capture at pc 7
        rd_ready = 1'b0;
        mode = 2'b11;
        trig_pc = 10'd7;
        pc_in = 10'h3FF;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int p = 0; p <= 10; p++) begin
            pc_in = PC_W'(p);
            regs_in = pack_regs(p + 100, p + 200, p + 300);
            step();
            if (p < 7) begin
                chk("trig_pre_count", 128'(count), 128'(0));
                chk("trig_pre_armed", 128'(armed), 128'(0));
            end else if (p == 7) begin
                chk("trig_count", 128'(count), 128'(1));
                chk("trig_armed", 128'(armed), 128'(1));
                chk("trig_pc", 128'(rd_data[REGS_W+NREG +: PC_W]), 128'(7));
            end
        end
        mode = 2'b01;
        step();
        chk("trig_disarm", 128'(armed), 128'(0));

        // Drop counter saturation
        mode = 2'b10;
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (16 + 260) step();
        chk("sat_drop_cnt", 128'(drop_cnt), 128'(255));
        chk("sat_overflow", 128'(overflow), 128'(1));

        // Random traffic against the model
        clear = 1'b1;
        step();
        clear = 1'b0;
        rdy_pct = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdy_pct = 10;
                    1:       rdy_pct = 50;
                    default: rdy_pct = 90;
                endcase
            end
            if ($urandom_range(0, 19) == 0) begin
                mode = 2'($urandom);
                trig_pc = PC_W'($urandom_range(0, 15));
            end
            rd_ready = ($urandom_range(0, 99) < rdy_pct);
            clear = ($urandom_range(0, 99) == 0);
            pc_in = PC_W'($urandom_range(0, 15));
            for (int r = 0; r < NREG; r++)
                if ($urandom_range(0, 3) == 0) regs_in[r*DATA_W +: DATA_W] = DATA_W'($urandom);
            step();
        end
        clear = 1'b0;

        // Async reset in the middle of a drain
        mode = 2'b10;
        rd_ready = 1'b0;
        repeat (6) step();
        mode = 2'b00;
        rd_ready = 1'b1;
        repeat (2) step();
        #2;
        mode = 2'b01;
        do_reset();
        step();
        chk("post_rst_count", 128'(count), 128'(1));
        chk("post_rst_mask", 128'(rd_data[REGS_W +: NREG]), 128'(3'b111));
        chk("post_rst_ts", 128'(rd_data[ENTRY_W-1 -: TS_W]), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
